// File: rtl/gpio_irq_pkg.sv
// gpio_irq_pkg
// Shared definitions for the GPIO input-event block: default sizing,
// register byte offsets (also consumed by the software header generator)
// and the word-index decode used by the APB register file.
package gpio_irq_pkg;

    localparam int GPIO_IRQ_N_GPIO = 13;
    localparam int GPIO_IRQ_DB_W   = 8;

    localparam logic [15:0] GPIO_IRQ_IN       = 16'h0000;
    localparam logic [15:0] GPIO_IRQ_RISE_EN  = 16'h0004;
    localparam logic [15:0] GPIO_IRQ_FALL_EN  = 16'h0008;
    localparam logic [15:0] GPIO_IRQ_STATUS   = 16'h000c;
    localparam logic [15:0] GPIO_IRQ_IRQ_EN   = 16'h0010;
    localparam logic [15:0] GPIO_IRQ_DEBOUNCE = 16'h0014;

    // Word index taken from paddr[4:2]; the two top slots are reserved.
    typedef enum logic [2:0] {
        REG_IN       = 3'd0,
        REG_RISE_EN  = 3'd1,
        REG_FALL_EN  = 3'd2,
        REG_STATUS   = 3'd3,
        REG_IRQ_EN   = 3'd4,
        REG_DEBOUNCE = 3'd5,
        REG_RSVD6    = 3'd6,
        REG_RSVD7    = 3'd7
    } reg_idx_e;

    function automatic reg_idx_e reg_idx(input logic [15:0] addr);
        return reg_idx_e'(addr[4:2]);
    endfunction

endpackage

// File: rtl/gpio_debounce.sv
// gpio_debounce
// Per-pin debounce filter. The filtered value follows the synchronised input
// only after the input has disagreed with it for T+1 consecutive cycles.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   s          : synchronised pin value
//   T          : debounce threshold (shared by all pins)
//   filt       : filtered pin value (registered)
//   upd        : high in the cycle whose closing edge updates filt
module gpio_debounce #(
    parameter int DB_W = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            s,
    input  logic [DB_W-1:0] T,
    output logic            filt,
    output logic            upd
);

    logic [DB_W-1:0] cnt;

    // Combinational so the top can latch the event on the same edge that
    // filt changes. The >= compare lets a lowered threshold take effect at
    // once even if cnt has already run past it.
    assign upd = (s != filt) && (cnt >= T);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            filt <= 1'b0;
        end else if (s == filt) begin
            cnt <= '0;
        end else if (upd) begin
            filt <= s;
            cnt  <= '0;
        end else if (cnt != '1) begin
            // Saturate rather than wrap so a long disagreement cannot
            // restart the count.
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/gpio_irq.sv
// gpio_irq
// Input-event companion to the GPIO block: synchronises and debounces the
// pad inputs, latches enabled rising/falling edges into a W1C status
// register and raises one level interrupt for any enabled status bit.
// Ports:
//   clk, rst_n       : clock, asynchronous active-low reset
//   apbs_*           : APB completer (paddr[4:2] decoded, zero wait states)
//   padin_gpio       : raw pad inputs, asynchronous to clk
//   irq              : |(STATUS & IRQ_EN), built from flop outputs only
module gpio_irq
    import gpio_irq_pkg::*;
#(
    parameter int N_GPIO = GPIO_IRQ_N_GPIO,
    parameter int DB_W   = GPIO_IRQ_DB_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              apbs_psel,
    input  logic              apbs_penable,
    input  logic              apbs_pwrite,
    input  logic [15:0]       apbs_paddr,
    input  logic [31:0]       apbs_pwdata,
    output logic [31:0]       apbs_prdata,
    output logic              apbs_pready,
    output logic              apbs_pslverr,
    input  logic [N_GPIO-1:0] padin_gpio,
    output logic              irq
);

    logic [N_GPIO-1:0] sync_p0;
    logic [N_GPIO-1:0] s;
    logic [N_GPIO-1:0] filt;
    logic [N_GPIO-1:0] upd;
    logic [N_GPIO-1:0] rise_en;
    logic [N_GPIO-1:0] fall_en;
    logic [N_GPIO-1:0] status;
    logic [N_GPIO-1:0] irq_en;
    logic [DB_W-1:0]   thresh;
    logic [N_GPIO-1:0] evt;
    logic [N_GPIO-1:0] w1c;
    logic              wr_en;
    reg_idx_e          idx;

    // Only the low bits of each write are stored; the rest is discarded.
    logic unused_pwdata;
    assign unused_pwdata = ^apbs_pwdata;

    assign apbs_pready  = 1'b1;
    assign apbs_pslverr = 1'b0;

    assign wr_en = apbs_psel & apbs_penable & apbs_pwrite;
    assign idx   = reg_idx(apbs_paddr);

    // Two-flop synchroniser per pad (sync_1bit array)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_p0 <= '0;
            s       <= '0;
        end else begin
            sync_p0 <= padin_gpio;
            s       <= sync_p0;
        end
    end

    // Debounce filter per pin
    for (genvar i = 0; i < N_GPIO; i++) begin : g_db
        gpio_debounce #(
            .DB_W(DB_W)
        ) u_db (
            .clk  (clk),
            .rst_n(rst_n),
            .s    (s[i]),
            .T    (thresh),
            .filt (filt[i]),
            .upd  (upd[i])
        );
    end

    // Events are qualified by the enables only at the moment filt updates,
    // so changing an enable later never produces a stale event.
    assign evt = upd & ((s & rise_en) | (~s & fall_en));
    assign w1c = (wr_en && idx == REG_STATUS) ? apbs_pwdata[N_GPIO-1:0] : '0;

    // Register file and status latch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rise_en <= '0;
            fall_en <= '0;
            status  <= '0;
            irq_en  <= '0;
            thresh  <= '0;
        end else begin
            // Clear first, then OR in new events: a same-cycle set wins.
            status <= (status & ~w1c) | evt;
            if (wr_en) begin
                case (idx)
                    REG_RISE_EN:  rise_en <= apbs_pwdata[N_GPIO-1:0];
                    REG_FALL_EN:  fall_en <= apbs_pwdata[N_GPIO-1:0];
                    REG_IRQ_EN:   irq_en  <= apbs_pwdata[N_GPIO-1:0];
                    REG_DEBOUNCE: thresh  <= apbs_pwdata[DB_W-1:0];
                    default:      ;
                endcase
            end
        end
    end

    // Read mux
    always_comb begin
        apbs_prdata = '0;
        case (idx)
            REG_IN:       apbs_prdata[N_GPIO-1:0] = filt;
            REG_RISE_EN:  apbs_prdata[N_GPIO-1:0] = rise_en;
            REG_FALL_EN:  apbs_prdata[N_GPIO-1:0] = fall_en;
            REG_STATUS:   apbs_prdata[N_GPIO-1:0] = status;
            REG_IRQ_EN:   apbs_prdata[N_GPIO-1:0] = irq_en;
            REG_DEBOUNCE: apbs_prdata[DB_W-1:0]   = thresh;
            default:      apbs_prdata = '0;
        endcase
    end

    assign irq = |(status & irq_en);

endmodule

// File: tb/tb_gpio_irq.sv
module tb_gpio_irq;

    localparam int N = 13;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          psel = 1'b0;
    logic          penable = 1'b0;
    logic          pwrite = 1'b0;
    logic [15:0]   paddr = '0;
    logic [31:0]   pwdata = '0;
    logic [31:0]   prdata;
    logic          pready;
    logic          pslverr;
    logic [N-1:0]  pad = '0;
    logic          irq;

    always #5 clk = ~clk;

    gpio_irq #(
        .N_GPIO(N),
        .DB_W  (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .apbs_psel   (psel),
        .apbs_penable(penable),
        .apbs_pwrite (pwrite),
        .apbs_paddr  (paddr),
        .apbs_pwdata (pwdata),
        .apbs_prdata (prdata),
        .apbs_pready (pready),
        .apbs_pslverr(pslverr),
        .padin_gpio  (pad),
        .irq         (irq)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: a pin's filtered value flips when the synchronised
    // input has disagreed with it over the last T+1 cycles.
    bit           model_on = 1'b0;
    int           t_m = 0;
    logic [N-1:0] rise_m = '0, fall_m = '0, irqen_m = '0;
    logic [N-1:0] filt_m = '0, status_m = '0, p0_m = '0;
    logic [N-1:0] s_hist [0:15];

    task automatic model_reset();
        filt_m = '0; status_m = '0; p0_m = '0;
        for (int i = 0; i < 16; i++) s_hist[i] = '0;
    endtask

    task automatic model_step();
        logic [N-1:0] ev;
        ev = '0;
        for (int p = 0; p < N; p++) begin
            bit all_diff;
            all_diff = 1'b1;
            for (int i = 0; i <= t_m; i++)
                if (s_hist[i][p] == filt_m[p]) all_diff = 1'b0;
            if (all_diff) begin
                filt_m[p] = ~filt_m[p];
                if (filt_m[p] && rise_m[p]) ev[p] = 1'b1;
                if (!filt_m[p] && fall_m[p]) ev[p] = 1'b1;
            end
        end
        if (psel && penable && pwrite && paddr[4:2] == 3'd3)
            status_m = status_m & ~pwdata[N-1:0];
        status_m = status_m | ev;
        for (int i = 15; i > 0; i--) s_hist[i] = s_hist[i-1];
        s_hist[0] = p0_m;
        p0_m = pad;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (model_on) model_step();
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    task automatic apb_write(input logic [15:0] a, input logic [31:0] d);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
        tick();
        penable = 1'b1;
        tick();
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    // Holds the bus in a read access phase; prdata is combinational.
    task automatic peek(input logic [15:0] a, output logic [31:0] d);
        psel = 1'b1; penable = 1'b1; pwrite = 1'b0; paddr = a;
        #1;
        d = prdata;
    endtask

    task automatic rand_seg(input int t, input int cycles);
        logic [31:0] d;
        model_on = 1'b0;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        pad = '0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        model_reset();
        t_m = t;
        rise_m = N'($urandom);
        fall_m = N'($urandom);
        irqen_m = N'($urandom);
        model_on = 1'b1;
        apb_write(16'h0014, 32'(t));
        apb_write(16'h0004, 32'(rise_m));
        apb_write(16'h0008, 32'(fall_m));
        apb_write(16'h0010, 32'(irqen_m));
        for (int c = 0; c < cycles; c++) begin
            pad = pad ^ N'($urandom & $urandom & $urandom);
            if ($urandom_range(0, 19) == 0) begin
                apb_write(16'h000c, $urandom);
            end else begin
                tick();
                peek(16'h0000, d);
                check($sformatf("rnd_in_t%0d", t), d, 32'(filt_m));
                peek(16'h000c, d);
                check($sformatf("rnd_status_t%0d", t), d, 32'(status_m));
                check($sformatf("rnd_irq_t%0d", t), 32'(irq), 32'(|(status_m & irqen_m)));
                check("rnd_pready_pslverr", {30'd0, pready, pslverr}, 32'h2);
            end
        end
        model_on = 1'b0;
        psel = 1'b0; penable = 1'b0;
    endtask

    typedef struct {
        logic [15:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    initial begin
        vec_t        vecs [13];
        logic [31:0] d;
        logic [31:0] acc;

        vecs[0]  = '{16'h0004, 32'hffffffff, 32'h00001fff};
        vecs[1]  = '{16'h0008, 32'h12345678, 32'h00001678};
        vecs[2]  = '{16'h0010, 32'ha5a5a5a5, 32'h000005a5};
        vecs[3]  = '{16'h0014, 32'hffffffff, 32'h000000ff};
        vecs[4]  = '{16'h0000, 32'hffffffff, 32'h00000000};
        vecs[5]  = '{16'h0018, 32'hffffffff, 32'h00000000};
        vecs[6]  = '{16'h001c, 32'hdeadbeef, 32'h00000000};
        vecs[7]  = '{16'h000c, 32'hffffffff, 32'h00000000};
        vecs[8]  = '{16'h0014, 32'h00000103, 32'h00000003};
        vecs[9]  = '{16'h0004, 32'h00000000, 32'h00000000};
        vecs[10] = '{16'h0008, 32'h00000000, 32'h00000000};
        vecs[11] = '{16'h0010, 32'h00000000, 32'h00000000};
        vecs[12] = '{16'h0014, 32'h00000000, 32'h00000000};

        // Reset state
        #2;
        for (int a = 0; a < 8; a++) begin
            peek(16'(a * 4), d);
            check($sformatf("reset_rd_%0h", a * 4), d, 32'h0);
        end
        check("reset_irq", 32'(irq), 32'h0);
        check("reset_pready_pslverr", {30'd0, pready, pslverr}, 32'h2);
        psel = 1'b0; penable = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick();

        // Register write/read-back table
        foreach (vecs[i]) begin
            apb_write(vecs[i].addr, vecs[i].wdata);
            peek(vecs[i].addr, d);
            check($sformatf("regtab_%0d_%0h", i, vecs[i].addr), d, vecs[i].exp);
            check("regtab_irq", 32'(irq), 32'h0);
        end

        // Rising edge with T = 0 on pin 0
        apb_write(16'h0004, 32'h1);
        apb_write(16'h0010, 32'h1);
        peek(16'h0000, d);
        pad[0] = 1'b1;
        tick(); tick();
        peek(16'h0000, d);
        check("rise_in_e2", d, 32'h0);
        check("rise_irq_e2", 32'(irq), 32'h0);
        tick();
        peek(16'h0000, d);
        check("rise_in_e3", d, 32'h1);
        check("rise_irq_e3", 32'(irq), 32'h1);
        peek(16'h000c, d);
        check("rise_status_e3", d, 32'h1);
        apb_write(16'h000c, 32'h1);
        check("rise_irq_after_w1c", 32'(irq), 32'h0);
        peek(16'h000c, d);
        check("rise_status_after_w1c", d, 32'h0);
        pad[0] = 1'b0;
        repeat (6) tick();

        // Debounce rejection and acceptance with T = 4 on pin 5
        apb_write(16'h0014, 32'd4);
        apb_write(16'h0004, 32'h20);
        peek(16'h0000, d);
        pad[5] = 1'b1;
        acc = '0;
        for (int c = 0; c < 14; c++) begin
            if (c == 4) pad[5] = 1'b0;
            tick();
            peek(16'h0000, d);
            acc = acc | d;
        end
        check("db_reject_in", acc, 32'h0);
        peek(16'h000c, d);
        check("db_reject_status", d, 32'h0);
        pad[5] = 1'b1;
        repeat (6) tick();
        peek(16'h0000, d);
        check("db_in_e6", d, 32'h0);
        tick();
        peek(16'h0000, d);
        check("db_in_e7", d, 32'h20);
        peek(16'h000c, d);
        check("db_status_e7", d, 32'h20);
        pad[5] = 1'b0;
        repeat (10) tick();
        apb_write(16'h000c, 32'h20);
        apb_write(16'h0004, 32'h0);

        // Falling edge on pin 12 with the interrupt masked
        pad[12] = 1'b1;
        repeat (10) tick();
        apb_write(16'h0008, 32'h1000);
        apb_write(16'h0010, 32'h0);
        pad[12] = 1'b0;
        repeat (10) tick();
        peek(16'h000c, d);
        check("fall_status", d, 32'h1000);
        check("fall_irq_masked", 32'(irq), 32'h0);
        apb_write(16'h0010, 32'h1000);
        check("fall_irq_unmasked", 32'(irq), 32'h1);
        apb_write(16'h000c, 32'h1000);
        check("fall_irq_cleared", 32'(irq), 32'h0);
        apb_write(16'h0010, 32'h0);
        apb_write(16'h0008, 32'h0);

        // Set/clear collision on pin 3 (T = 0): event and W1C share an edge
        apb_write(16'h0014, 32'd0);
        apb_write(16'h0004, 32'h8);
        pad[3] = 1'b1;
        tick();
        apb_write(16'h000c, 32'h8);
        peek(16'h000c, d);
        check("collision_set_wins", d, 32'h8);
        apb_write(16'h000c, 32'h8);
        peek(16'h000c, d);
        check("collision_later_clear", d, 32'h0);
        pad[3] = 1'b0;
        repeat (5) tick();

        // Reset in the middle of a long count
        apb_write(16'h0014, 32'd200);
        apb_write(16'h0004, 32'h2);
        apb_write(16'h0010, 32'h2);
        pad[1] = 1'b1;
        repeat (50) tick();
        rst_n = 1'b0;
        #1;
        for (int a = 0; a < 6; a++) begin
            peek(16'(a * 4), d);
            check($sformatf("midrst_rd_%0h", a * 4), d, 32'h0);
        end
        check("midrst_irq", 32'(irq), 32'h0);
        psel = 1'b0; penable = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick(); tick();
        peek(16'h0000, d);
        check("midrst_in_e2", d, 32'h0);
        tick();
        peek(16'h0000, d);
        check("midrst_in_e3", d, 32'h2);
        peek(16'h000c, d);
        check("midrst_status", d, 32'h0);
        check("midrst_pready_pslverr", {30'd0, pready, pslverr}, 32'h2);
        psel = 1'b0; penable = 1'b0;

        // Randomised pads against the reference model
        rand_seg(0, 500);
        rand_seg(2, 500);
        rand_seg(5, 500);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
